instr_sequencer: RTL and testbench

- Control sequencer downstream of the instruction register.
- Consumes the decoded IR fields (opcode, rd, rs_1, rs_2, S) and drives every bus-enable, register-load and memory strobe of the single-W-bus datapath.
- Runs the fetch / decode / execute cycle as a Moore FSM, with a memory wait handshake and a memory-timeout fault.

---
 rtl/instr_sequencer_pkg.sv | 77 +++++++
 rtl/instr_sequencer_wait_timer.sv | 32 +++
 rtl/instr_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_instr_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcode map, ALU function codes,
// FSM state encoding and the opcode-to-class decode used by the control FSM.
package instr_sequencer_pkg;

    localparam int OPC_W = 4;
    localparam int REG_W = 3;
    localparam int CNT_W = 8;

    localparam logic [OPC_W-1:0] OP_NOP   = 4'h0;
    localparam logic [OPC_W-1:0] OP_ADD   = 4'h1;
    localparam logic [OPC_W-1:0] OP_SUB   = 4'h2;
    localparam logic [OPC_W-1:0] OP_AND   = 4'h3;
    localparam logic [OPC_W-1:0] OP_OR    = 4'h4;
    localparam logic [OPC_W-1:0] OP_XOR   = 4'h5;
    localparam logic [OPC_W-1:0] OP_NOT   = 4'h6;
    localparam logic [OPC_W-1:0] OP_MOV   = 4'h7;
    localparam logic [OPC_W-1:0] OP_LOAD  = 4'h8;
    localparam logic [OPC_W-1:0] OP_STORE = 4'h9;
    localparam logic [OPC_W-1:0] OP_JMP   = 4'hA;
    localparam logic [OPC_W-1:0] OP_BZ    = 4'hB;
    localparam logic [OPC_W-1:0] OP_HALT  = 4'hF;

    // ALU function codes share the opcode numbering, so alu_op is the opcode itself
    typedef enum logic [OPC_W-1:0] {
        ALU_NONE = 4'h0,
        ALU_ADD  = 4'h1,
        ALU_SUB  = 4'h2,
        ALU_AND  = 4'h3,
        ALU_OR   = 4'h4,
        ALU_XOR  = 4'h5,
        ALU_NOT  = 4'h6,
        ALU_MOV  = 4'h7
    } alu_fn_e;

    typedef enum logic [3:0] {
        ST_FETCH0 = 4'd0,
        ST_FETCH1 = 4'd1,
        ST_FETCH2 = 4'd2,
        ST_DECODE = 4'd3,
        ST_EX1    = 4'd4,
        ST_EX2    = 4'd5,
        ST_EX3    = 4'd6,
        ST_HALTED = 4'd7,
        ST_FAULT  = 4'd8
    } state_e;

    typedef enum logic [2:0] {
        CL_NOP,
        CL_ALU,
        CL_LOAD,
        CL_STORE,
        CL_JMP,
        CL_BZ,
        CL_HALT,
        CL_ILLEGAL
    } op_class_e;

    function automatic op_class_e classify(input logic [OPC_W-1:0] op);
        op_class_e cls;
        if (op == OP_NOP) begin
            cls = CL_NOP;
        end else if (op <= OP_MOV) begin
            cls = CL_ALU;
        end else begin
            case (op)
                OP_LOAD:  cls = CL_LOAD;
                OP_STORE: cls = CL_STORE;
                OP_JMP:   cls = CL_JMP;
                OP_BZ:    cls = CL_BZ;
                OP_HALT:  cls = CL_HALT;
                default:  cls = CL_ILLEGAL;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/instr_sequencer_wait_timer.sv
// Memory wait-state counter: counts cycles without mem_ready while a strobe is held
// and flags the cycle in which the wait limit is hit.
module instr_sequencer_wait_timer
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_active,
    input  logic i_mem_ready,
    output logic o_timeout
);

    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_active) begin
            r_cnt <= '0;
        end else if (!i_mem_ready) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Fires on the cycle whose idle count would bring the total to TIMEOUT
    assign o_timeout = i_active && !i_mem_ready && (r_cnt == LAST_WAIT);

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute control sequencer for the single-W-bus datapath.
// Moore FSM: all strobes decode from the state register plus the IR fields.
//
// state   | meaning
// FETCH0  | PC onto bus, load MAR
// FETCH1  | memory read, wait for mem_ready
// FETCH2  | MDR onto bus, load IR, increment PC
// DECODE  | branch on opcode, flag illegal opcodes
// EX1-EX3 | execute steps of the current instruction class
// HALTED  | HALT executed, sticky until reset
// FAULT   | memory timeout, sticky until reset
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT      = 16,
    parameter bit          RESET_STATE_HALT = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [OPC_W-1:0] i_opcode,
    input  logic [REG_W-1:0] i_rd,
    input  logic [REG_W-1:0] i_rs_1,
    input  logic [REG_W-1:0] i_rs_2,
    input  logic             i_s,
    input  logic             i_zero_flag,
    input  logic             i_mem_ready,
    output logic             o_pc_out,
    output logic             o_pc_inc,
    output logic             o_pc_in,
    output logic             o_mar_in,
    output logic             o_mdr_in,
    output logic             o_mdr_out,
    output logic             o_mem_rd,
    output logic             o_mem_wr,
    output logic             o_ir_in,
    output logic             o_reg_out_en,
    output logic [REG_W-1:0] o_reg_out_sel,
    output logic             o_reg_in_en,
    output logic [REG_W-1:0] o_reg_in_sel,
    output logic             o_a_in,
    output logic             o_c_in,
    output logic             o_c_out,
    output logic [OPC_W-1:0] o_alu_op,
    output logic             o_flag_we,
    output logic             o_halted,
    output logic             o_fault,
    output logic             o_illegal
);

    localparam state_e RESET_STATE = RESET_STATE_HALT ? ST_HALTED : ST_FETCH0;

    state_e    r_state;
    state_e    w_next;
    logic      r_boot;
    op_class_e w_cls;
    logic      w_wait;
    logic      w_timeout;

    assign w_cls = classify(i_opcode);

    always_comb begin
        w_wait = 1'b0;
        if (!r_boot) begin
            w_wait = (r_state == ST_FETCH1)
                  || ((r_state == ST_EX2) && (w_cls == CL_LOAD))
                  || ((r_state == ST_EX3) && (w_cls == CL_STORE));
        end
    end

    instr_sequencer_wait_timer #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_active    (w_wait),
        .i_mem_ready (i_mem_ready),
        .o_timeout   (w_timeout)
    );

    always_comb begin
        w_next = r_state;
        if (w_wait) begin
            if (i_mem_ready) begin
                case (r_state)
                    ST_FETCH1: w_next = ST_FETCH2;
                    ST_EX2:    w_next = ST_EX3;
                    default:   w_next = ST_FETCH0;
                endcase
            end else if (w_timeout) begin
                w_next = ST_FAULT;
            end
        end else begin
            case (r_state)
                ST_FETCH0: w_next = ST_FETCH1;
                ST_FETCH2: w_next = ST_DECODE;
                ST_DECODE: begin
                    case (w_cls)
                        CL_NOP, CL_ILLEGAL: w_next = ST_FETCH0;
                        CL_HALT:            w_next = ST_HALTED;
                        default:            w_next = ST_EX1;
                    endcase
                end
                ST_EX1:    w_next = ((w_cls == CL_JMP) || (w_cls == CL_BZ)) ? ST_FETCH0 : ST_EX2;
                ST_EX2:    w_next = ST_EX3;
                ST_EX3:    w_next = ST_FETCH0;
                default:   w_next = r_state;
            endcase
        end
    end

    // r_boot holds every output low for the first cycle after reset release
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RESET_STATE;
            r_boot  <= 1'b1;
        end else if (r_boot) begin
            r_boot  <= 1'b0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        o_pc_out      = 1'b0;
        o_pc_inc      = 1'b0;
        o_pc_in       = 1'b0;
        o_mar_in      = 1'b0;
        o_mdr_in      = 1'b0;
        o_mdr_out     = 1'b0;
        o_mem_rd      = 1'b0;
        o_mem_wr      = 1'b0;
        o_ir_in       = 1'b0;
        o_reg_out_en  = 1'b0;
        o_reg_out_sel = '0;
        o_reg_in_en   = 1'b0;
        o_reg_in_sel  = '0;
        o_a_in        = 1'b0;
        o_c_in        = 1'b0;
        o_c_out       = 1'b0;
        o_alu_op      = '0;
        o_halted      = 1'b0;
        o_fault       = 1'b0;
        o_illegal     = 1'b0;
        if (!r_boot) begin
            case (r_state)
                ST_FETCH0: begin
                    o_pc_out = 1'b1;
                    o_mar_in = 1'b1;
                end
                ST_FETCH1: o_mem_rd = 1'b1;
                ST_FETCH2: begin
                    o_mdr_out = 1'b1;
                    o_ir_in   = 1'b1;
                    o_pc_inc  = 1'b1;
                end
                ST_DECODE: o_illegal = (w_cls == CL_ILLEGAL);
                ST_EX1: begin
                    if ((w_cls == CL_ALU) || (w_cls == CL_LOAD) || (w_cls == CL_STORE)
                        || (w_cls == CL_JMP) || ((w_cls == CL_BZ) && i_zero_flag)) begin
                        o_reg_out_en  = 1'b1;
                        o_reg_out_sel = i_rs_1;
                    end
                    o_a_in   = (w_cls == CL_ALU);
                    o_mar_in = (w_cls == CL_LOAD) || (w_cls == CL_STORE);
                    o_pc_in  = (w_cls == CL_JMP) || ((w_cls == CL_BZ) && i_zero_flag);
                end
                ST_EX2: begin
                    if ((w_cls == CL_ALU) || (w_cls == CL_STORE)) begin
                        o_reg_out_en  = 1'b1;
                        o_reg_out_sel = i_rs_2;
                    end
                    if (w_cls == CL_ALU) begin
                        o_alu_op = i_opcode;
                        o_c_in   = 1'b1;
                    end
                    o_mdr_in = (w_cls == CL_STORE);
                    o_mem_rd = (w_cls == CL_LOAD);
                end
                ST_EX3: begin
                    if ((w_cls == CL_ALU) || (w_cls == CL_LOAD)) begin
                        o_reg_in_en  = 1'b1;
                        o_reg_in_sel = i_rd;
                    end
                    o_c_out   = (w_cls == CL_ALU);
                    o_mdr_out = (w_cls == CL_LOAD);
                    o_mem_wr  = (w_cls == CL_STORE);
                end
                ST_HALTED: o_halted = 1'b1;
                ST_FAULT:  o_fault  = 1'b1;
                default: ;
            endcase
        end
    end

    assign o_flag_we = o_c_in & i_s;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus pushes the expected strobe set of
// every cycle, a negedge monitor pops and compares against the DUT outputs.
module tb_instr_sequencer;

    localparam int T = 4;

    typedef struct packed {
        logic       pc_out;
        logic       pc_inc;
        logic       pc_in;
        logic       mar_in;
        logic       mdr_in;
        logic       mdr_out;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_in;
        logic       reg_out_en;
        logic [2:0] reg_out_sel;
        logic       reg_in_en;
        logic [2:0] reg_in_sel;
        logic       a_in;
        logic       c_in;
        logic       c_out;
        logic [3:0] alu_op;
        logic       flag_we;
        logic       halted;
        logic       fault;
        logic       illegal;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode = '0;
    logic [2:0] rd = '0, rs_1 = '0, rs_2 = '0;
    logic       s_bit = 1'b0, zero_flag = 1'b0, mem_ready = 1'b0;

    logic       pc_out, pc_inc, pc_in, mar_in, mdr_in, mdr_out, mem_rd, mem_wr, ir_in;
    logic       reg_out_en, reg_in_en, a_in, c_in, c_out, flag_we, halted, fault, illegal;
    logic [2:0] reg_out_sel, reg_in_sel;
    logic [3:0] alu_op;

    logic [3:0] p_op;
    logic [2:0] p_rd, p_rs1, p_rs2;
    logic       p_s, p_zf;

    int   checks = 0;
    int   errors = 0;
    ctl_t exp_q[$];
    ctl_t act;

    always #5 clk = ~clk;

    instr_sequencer #(
        .MEM_TIMEOUT      (T),
        .RESET_STATE_HALT (1'b0)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_opcode      (opcode),
        .i_rd          (rd),
        .i_rs_1        (rs_1),
        .i_rs_2        (rs_2),
        .i_s           (s_bit),
        .i_zero_flag   (zero_flag),
        .i_mem_ready   (mem_ready),
        .o_pc_out      (pc_out),
        .o_pc_inc      (pc_inc),
        .o_pc_in       (pc_in),
        .o_mar_in      (mar_in),
        .o_mdr_in      (mdr_in),
        .o_mdr_out     (mdr_out),
        .o_mem_rd      (mem_rd),
        .o_mem_wr      (mem_wr),
        .o_ir_in       (ir_in),
        .o_reg_out_en  (reg_out_en),
        .o_reg_out_sel (reg_out_sel),
        .o_reg_in_en   (reg_in_en),
        .o_reg_in_sel  (reg_in_sel),
        .o_a_in        (a_in),
        .o_c_in        (c_in),
        .o_c_out       (c_out),
        .o_alu_op      (alu_op),
        .o_flag_we     (flag_we),
        .o_halted      (halted),
        .o_fault       (fault),
        .o_illegal     (illegal)
    );

    always_comb begin
        act             = '0;
        act.pc_out      = pc_out;
        act.pc_inc      = pc_inc;
        act.pc_in       = pc_in;
        act.mar_in      = mar_in;
        act.mdr_in      = mdr_in;
        act.mdr_out     = mdr_out;
        act.mem_rd      = mem_rd;
        act.mem_wr      = mem_wr;
        act.ir_in       = ir_in;
        act.reg_out_en  = reg_out_en;
        act.reg_out_sel = reg_out_sel;
        act.reg_in_en   = reg_in_en;
        act.reg_in_sel  = reg_in_sel;
        act.a_in        = a_in;
        act.c_in        = c_in;
        act.c_out       = c_out;
        act.alu_op      = alu_op;
        act.flag_we     = flag_we;
        act.halted      = halted;
        act.fault       = fault;
        act.illegal     = illegal;
    end

    initial begin : monitor
        ctl_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got %h exp %h", $time, act, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got %0h exp %0h", name, $time, got, want);
        end
    endtask

    function automatic logic noise();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic tick(input logic rdy, input bit ld, input ctl_t e);
        @(posedge clk);
        #1;
        mem_ready = rdy;
        if (ld) begin
            opcode    = p_op;
            rd        = p_rd;
            rs_1      = p_rs1;
            rs_2      = p_rs2;
            s_bit     = p_s;
            zero_flag = p_zf;
        end
        exp_q.push_back(e);
    endtask

    // Reset for a few cycles; the release cycle itself must still show all outputs low
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        mem_ready = noise();
        exp_q.push_back('0);
        @(posedge clk);
        #1;
        exp_q.push_back('0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back('0);
    endtask

    task automatic fault_tail();
        ctl_t f;
        f       = '0;
        f.fault = 1'b1;
        repeat (6) tick(noise(), 1'b0, f);
        do_reset();
    endtask

    task automatic mem_access(input int waits, input ctl_t e, output bit timed_out);
        timed_out = 1'b0;
        if (waits >= T) begin
            repeat (T) tick(1'b0, 1'b0, e);
            timed_out = 1'b1;
            fault_tail();
        end else begin
            repeat (waits) tick(1'b0, 1'b0, e);
            tick(1'b1, 1'b0, e);
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [2:0] d, input logic [2:0] a,
                             input logic [2:0] b, input logic sf, input logic zf,
                             input int fw, input int ew, input int hold);
        ctl_t e;
        bit   to;
        bit   bad;
        p_op = op; p_rd = d; p_rs1 = a; p_rs2 = b; p_s = sf; p_zf = zf;
        bad = (op >= 4'hC) && (op <= 4'hE);

        e = '0; e.pc_out = 1'b1; e.mar_in = 1'b1;
        tick(noise(), 1'b0, e);
        e = '0; e.mem_rd = 1'b1;
        mem_access(fw, e, to);
        if (to) return;
        e = '0; e.mdr_out = 1'b1; e.ir_in = 1'b1; e.pc_inc = 1'b1;
        tick(noise(), 1'b0, e);
        e = '0; e.illegal = bad;
        tick(noise(), 1'b1, e);

        if (op == 4'hF) begin
            e = '0; e.halted = 1'b1;
            repeat (hold) tick(noise(), 1'b0, e);
            do_reset();
        end else if (op >= 4'h1 && op <= 4'h7) begin
            e = '0; e.reg_out_en = 1'b1; e.reg_out_sel = a; e.a_in = 1'b1;
            tick(noise(), 1'b0, e);
            e = '0; e.reg_out_en = 1'b1; e.reg_out_sel = b; e.alu_op = op;
            e.c_in = 1'b1; e.flag_we = sf;
            tick(noise(), 1'b0, e);
            e = '0; e.c_out = 1'b1; e.reg_in_en = 1'b1; e.reg_in_sel = d;
            tick(noise(), 1'b0, e);
        end else if (op == 4'h8) begin
            e = '0; e.reg_out_en = 1'b1; e.reg_out_sel = a; e.mar_in = 1'b1;
            tick(noise(), 1'b0, e);
            e = '0; e.mem_rd = 1'b1;
            mem_access(ew, e, to);
            if (to) return;
            e = '0; e.mdr_out = 1'b1; e.reg_in_en = 1'b1; e.reg_in_sel = d;
            tick(noise(), 1'b0, e);
        end else if (op == 4'h9) begin
            e = '0; e.reg_out_en = 1'b1; e.reg_out_sel = a; e.mar_in = 1'b1;
            tick(noise(), 1'b0, e);
            e = '0; e.reg_out_en = 1'b1; e.reg_out_sel = b; e.mdr_in = 1'b1;
            tick(noise(), 1'b0, e);
            e = '0; e.mem_wr = 1'b1;
            mem_access(ew, e, to);
        end else if (op == 4'hA || op == 4'hB) begin
            e = '0;
            if (op == 4'hA || zf) begin
                e.reg_out_en = 1'b1; e.reg_out_sel = a; e.pc_in = 1'b1;
            end
            tick(noise(), 1'b0, e);
        end
    endtask

    task automatic reset_mid_fetch();
        ctl_t e;
        e = '0; e.pc_out = 1'b1; e.mar_in = 1'b1;
        tick(1'b0, 1'b0, e);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        check("mem_rd_fetch1", 32'(mem_rd), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mem_rd_drop_on_reset", 32'(mem_rd), 32'd0);
        check("outputs_in_reset", 32'(act), 32'd0);
        exp_q.push_back('0);
        @(posedge clk);
        #1;
        exp_q.push_back('0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back('0);
    endtask

    function automatic int pick_wait();
        if ($urandom_range(0, 19) == 0) return T;
        return int'($urandom_range(0, T - 1));
    endfunction

    initial begin : stimulus
        do_reset();
        reset_mid_fetch();
        run_instr(4'h1, 3'd3, 3'd1, 3'd2, 1'b1, 1'b0, 0, 0, 5);
        run_instr(4'h8, 3'd5, 3'd2, 3'd0, 1'b0, 1'b0, 0, 3, 5);
        run_instr(4'hB, 3'd0, 3'd6, 3'd1, 1'b0, 1'b0, 1, 0, 5);
        run_instr(4'hB, 3'd0, 3'd6, 3'd1, 1'b0, 1'b1, 0, 0, 5);
        run_instr(4'hA, 3'd0, 3'd4, 3'd0, 1'b0, 1'b0, 2, 0, 5);
        run_instr(4'h9, 3'd0, 3'd7, 3'd3, 1'b0, 1'b0, 0, T - 1, 5);
        run_instr(4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 0, 0, 5);
        run_instr(4'hD, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0, 0, 0, 5);
        run_instr(4'h2, 3'd7, 3'd5, 3'd4, 1'b0, 1'b1, 0, 0, 5);
        run_instr(4'h3, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, T, 0, 5);
        run_instr(4'h8, 3'd2, 3'd3, 3'd0, 1'b0, 1'b0, 0, T, 5);
        run_instr(4'hF, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 0, 0, 50);
        for (int i = 0; i < 300; i++) begin
            run_instr(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      pick_wait(), pick_wait(), 5);
        end
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
